// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC sequencing, instruction-memory handshake and 2-bit BTB predictor
// Revision : 1.0
// ============================================================================
module fetch_stage #(
  parameter int                  XLEN         = 32,
  parameter int                  VPC_BITS     = 32,
  parameter int                  BTB_IDX_BITS = 4,
  parameter logic [VPC_BITS-1:0] RESET_PC     = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_D,
  input  logic                MEM_stall,
  input  logic                Itlb_stall,
  input  logic                EX_taken,
  input  logic [VPC_BITS-1:0] EX_target_pc,
  input  logic                EX_upd_valid,
  input  logic [VPC_BITS-1:0] EX_upd_pc,
  input  logic                EX_upd_taken,
  input  logic [VPC_BITS-1:0] EX_upd_target,
  output logic                imem_req,
  output logic [VPC_BITS-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic [VPC_BITS-1:0] F_pc,
  output logic [XLEN-1:0]     F_inst,
  output logic                F_BP_taken,
  output logic [VPC_BITS-1:0] F_BP_target_pc
);

  localparam int              BTB_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int              TAG_BITS    = VPC_BITS - BTB_IDX_BITS - 2;
  localparam logic [XLEN-1:0] NOP_INST    = XLEN'(32'h2000_0000);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [VPC_BITS-1:0] pc_q, pc_d;
  logic [XLEN-1:0]     buf_inst_q, buf_inst_d;
  logic                buf_taken_q, buf_taken_d;
  logic [VPC_BITS-1:0] buf_target_q, buf_target_d;

  logic [BTB_ENTRIES-1:0]                btb_valid_q, btb_valid_d;
  logic [BTB_ENTRIES-1:0][TAG_BITS-1:0]  btb_tag_q, btb_tag_d;
  logic [BTB_ENTRIES-1:0][VPC_BITS-1:0]  btb_target_q, btb_target_d;
  logic [BTB_ENTRIES-1:0][1:0]           btb_cnt_q, btb_cnt_d;

  logic [BTB_IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]     lk_tag, up_tag;
  logic                    lk_taken, up_hit;
  logic [VPC_BITS-1:0]     lk_target, pc_seq;
  logic                    hold, issue, resp, outstanding;
  logic                    present_live, present_buf;
  logic                    upd_pc_unused;

  assign upd_pc_unused = ^EX_upd_pc[1:0];

  // Lookup reads the registered arrays, so a same-cycle update is not visible yet.
  always_comb begin
    lk_idx    = pc_q[BTB_IDX_BITS+1:2];
    lk_tag    = pc_q[VPC_BITS-1:BTB_IDX_BITS+2];
    lk_taken  = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag) && btb_cnt_q[lk_idx][1];
    lk_target = lk_taken ? btb_target_q[lk_idx] : '0;
    up_idx    = EX_upd_pc[BTB_IDX_BITS+1:2];
    up_tag    = EX_upd_pc[VPC_BITS-1:BTB_IDX_BITS+2];
    up_hit    = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
  end

  always_comb begin
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    btb_cnt_d    = btb_cnt_q;
    if (EX_upd_valid) begin
      if (up_hit) begin
        if (EX_upd_taken) begin
          btb_cnt_d[up_idx]    = (btb_cnt_q[up_idx] == 2'd3) ? 2'd3 : btb_cnt_q[up_idx] + 2'd1;
          btb_target_d[up_idx] = EX_upd_target;
        end else begin
          btb_cnt_d[up_idx]    = (btb_cnt_q[up_idx] == 2'd0) ? 2'd0 : btb_cnt_q[up_idx] - 2'd1;
        end
      end else if (EX_upd_taken) begin
        btb_valid_d[up_idx]  = 1'b1;
        btb_tag_d[up_idx]    = up_tag;
        btb_target_d[up_idx] = EX_upd_target;
        btb_cnt_d[up_idx]    = 2'd2;
      end
    end
  end

  // A response only counts while a request of ours is in flight.
  always_comb begin
    hold        = stall_D | MEM_stall;
    issue       = (state_q == S_REQ) && !Itlb_stall;
    resp        = imem_ready && (issue || (state_q == S_WAIT));
    outstanding = !imem_ready && (issue || (state_q == S_WAIT) || (state_q == S_DROP));
    pc_seq      = pc_q + VPC_BITS'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      buf_inst_q   <= '0;
      buf_taken_q  <= 1'b0;
      buf_target_q <= '0;
      btb_valid_q  <= '0;
      btb_tag_q    <= '0;
      btb_target_q <= '0;
      btb_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_inst_q   <= buf_inst_d;
      buf_taken_q  <= buf_taken_d;
      buf_target_q <= buf_target_d;
      btb_valid_q  <= btb_valid_d;
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
      btb_cnt_q    <= btb_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_inst_d   = buf_inst_q;
    buf_taken_d  = buf_taken_q;
    buf_target_d = buf_target_q;
    if (EX_taken) begin
      pc_d         = EX_target_pc;
      buf_inst_d   = '0;
      buf_taken_d  = 1'b0;
      buf_target_d = '0;
      state_d      = outstanding ? S_DROP : S_REQ;
    end else begin
      case (state_q)
        S_REQ, S_WAIT: begin
          if (resp) begin
            if (hold) begin
              buf_inst_d   = imem_rdata;
              buf_taken_d  = lk_taken;
              buf_target_d = lk_target;
              state_d      = S_HOLD;
            end else begin
              pc_d    = lk_taken ? lk_target : pc_seq;
              state_d = S_REQ;
            end
          end else if (issue) begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (!hold) begin
            pc_d    = buf_taken_q ? buf_target_q : pc_seq;
            state_d = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_ready) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    present_live   = resp && !EX_taken && !rst;
    present_buf    = (state_q == S_HOLD) && !EX_taken && !rst;
    imem_req       = issue && !rst;
    imem_addr      = pc_q;
    F_pc           = rst ? '0 : pc_q;
    F_inst         = NOP_INST;
    F_BP_taken     = 1'b0;
    F_BP_target_pc = '0;
    if (present_live) begin
      F_inst         = imem_rdata;
      F_BP_taken     = lk_taken;
      F_BP_target_pc = lk_target;
    end else if (present_buf) begin
      F_inst         = buf_inst_q;
      F_BP_taken     = buf_taken_q;
      F_BP_target_pc = buf_target_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed cycle-by-cycle vectors for fetch_stage
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst, stall_D, MEM_stall, Itlb_stall, EX_taken;
  logic [31:0] EX_target_pc, EX_upd_pc, EX_upd_target;
  logic        EX_upd_valid, EX_upd_taken;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata, F_pc, F_inst, F_BP_target_pc;
  logic        F_BP_taken;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_D(stall_D), .MEM_stall(MEM_stall), .Itlb_stall(Itlb_stall),
    .EX_taken(EX_taken), .EX_target_pc(EX_target_pc),
    .EX_upd_valid(EX_upd_valid), .EX_upd_pc(EX_upd_pc), .EX_upd_taken(EX_upd_taken),
    .EX_upd_target(EX_upd_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .F_pc(F_pc), .F_inst(F_inst), .F_BP_taken(F_BP_taken), .F_BP_target_pc(F_BP_target_pc)
  );

  typedef struct {
    logic        rst, stl, mst, itl, ext;
    logic [31:0] ext_pc;
    logic        upv;
    logic [31:0] up_pc;
    logic        up_tk;
    logic [31:0] up_tgt;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr, e_pc, e_inst;
    logic        e_bpt;
    logic [31:0] e_bptgt;
  } vec_t;

  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t mk(
    input logic r, stl, mst, itl, ext, input logic [31:0] ext_pc,
    input logic upv, input logic [31:0] up_pc, input logic up_tk, input logic [31:0] up_tgt,
    input logic rdy, input logic [31:0] rdata,
    input logic e_req, input logic [31:0] e_addr, e_pc, e_inst, input logic e_bpt,
    input logic [31:0] e_bptgt);
    vec_t v;
    v.rst = r; v.stl = stl; v.mst = mst; v.itl = itl; v.ext = ext; v.ext_pc = ext_pc;
    v.upv = upv; v.up_pc = up_pc; v.up_tk = up_tk; v.up_tgt = up_tgt;
    v.rdy = rdy; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_inst = e_inst;
    v.e_bpt = e_bpt; v.e_bptgt = e_bptgt;
    return v;
  endfunction

  task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rise.
  task automatic run(input vec_t v, input int step);
    @(negedge clk);
    rst = v.rst; stall_D = v.stl; MEM_stall = v.mst; Itlb_stall = v.itl;
    EX_taken = v.ext; EX_target_pc = v.ext_pc;
    EX_upd_valid = v.upv; EX_upd_pc = v.up_pc; EX_upd_taken = v.up_tk; EX_upd_target = v.up_tgt;
    imem_ready = v.rdy; imem_rdata = v.rdata;
    #1;
    check("imem_req",       step, {31'b0, imem_req},   {31'b0, v.e_req});
    check("imem_addr",      step, imem_addr,           v.e_addr);
    check("F_pc",           step, F_pc,                v.e_pc);
    check("F_inst",         step, F_inst,              v.e_inst);
    check("F_BP_taken",     step, {31'b0, F_BP_taken}, {31'b0, v.e_bpt});
    check("F_BP_target_pc", step, F_BP_target_pc,      v.e_bptgt);
  endtask

  initial begin
    rst = 1'b1; stall_D = 1'b0; MEM_stall = 1'b0; Itlb_stall = 1'b0; EX_taken = 1'b0;
    EX_target_pc = '0; EX_upd_valid = 1'b0; EX_upd_pc = '0; EX_upd_taken = 1'b0;
    EX_upd_target = '0; imem_ready = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);

    //            rst stl mst itl ext ext_pc      upv up_pc   tk up_tgt   rdy rdata            req addr    pc      inst             bpt bptgt
    tbl.push_back(mk(1,0,0,0, 0,'h0,   0,'h0, 0,'h0,   0,'h0,          0,'h0,  'h0,  NOP,          0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0000,  1,'h0,  'h0,  'hC000_0000,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0004,  1,'h4,  'h4,  'hC000_0004,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0008,  1,'h8,  'h8,  'hC000_0008,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_000C,  1,'hC,  'hC,  'hC000_000C,  0,'h0));
    // slow memory at 0x10: three empty cycles
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   0,'h0,          1,'h10, 'h10, NOP,          0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   0,'h0,          0,'h10, 'h10, NOP,          0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   0,'h0,          0,'h10, 'h10, NOP,          0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0010,  0,'h10, 'h10, 'hC000_0010,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0014,  1,'h14, 'h14, 'hC000_0014,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0018,  1,'h18, 'h18, 'hC000_0018,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_001C,  1,'h1C, 'h1C, 'hC000_001C,  0,'h0));
    // decode stall at 0x20 for two cycles
    tbl.push_back(mk(0,1,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0020,  1,'h20, 'h20, 'hC000_0020,  0,'h0));
    tbl.push_back(mk(0,1,0,0, 0,'h0,   0,'h0, 0,'h0,   0,'h0,          0,'h20, 'h20, 'hC000_0020,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   0,'h0,          0,'h20, 'h20, 'hC000_0020,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0024,  1,'h24, 'h24, 'hC000_0024,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0028,  1,'h28, 'h28, 'hC000_0028,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_002C,  1,'h2C, 'h2C, 'hC000_002C,  0,'h0));
    // ITLB miss at 0x30
    tbl.push_back(mk(0,0,0,1, 0,'h0,   0,'h0, 0,'h0,   0,'h0,          0,'h30, 'h30, NOP,          0,'h0));
    tbl.push_back(mk(0,0,0,1, 0,'h0,   0,'h0, 0,'h0,   0,'h0,          0,'h30, 'h30, NOP,          0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0030,  1,'h30, 'h30, 'hC000_0030,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0034,  1,'h34, 'h34, 'hC000_0034,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0038,  1,'h38, 'h38, 'hC000_0038,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_003C,  1,'h3C, 'h3C, 'hC000_003C,  0,'h0));
    // redirect while waiting at 0x40: stale response must be dropped
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   0,'h0,          1,'h40, 'h40, NOP,          0,'h0));
    tbl.push_back(mk(0,0,0,0, 1,'h100, 0,'h0, 0,'h0,   0,'h0,          0,'h40, 'h40, NOP,          0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0040,  0,'h100,'h100,NOP,          0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0100,  1,'h100,'h100,'hC000_0100,  0,'h0));
    // train 0x80 -> 0x200 twice, then redirect to 0x80 as the pending response arrives
    tbl.push_back(mk(0,0,0,0, 0,'h0,   1,'h80,1,'h200, 0,'h0,          1,'h104,'h104,NOP,          0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   1,'h80,1,'h200, 0,'h0,          0,'h104,'h104,NOP,          0,'h0));
    tbl.push_back(mk(0,0,0,0, 1,'h80,  0,'h0, 0,'h0,   1,'hC000_0104,  0,'h104,'h104,NOP,          0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0080,  1,'h80, 'h80, 'hC000_0080,  1,'h200));
    // 0x200 aliases BTB index 0 with a different tag
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0200,  1,'h200,'h200,'hC000_0200,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 1,'h80,  0,'h0, 0,'h0,   1,'hC000_0204,  1,'h204,'h204,NOP,          0,'h0));
    // memory stall with not-taken updates: lookup sees old counter, buffer keeps the prediction
    tbl.push_back(mk(0,0,1,0, 0,'h0,   1,'h80,0,'h0,   1,'hC000_0080,  1,'h80, 'h80, 'hC000_0080,  1,'h200));
    tbl.push_back(mk(0,0,1,0, 0,'h0,   1,'h80,0,'h0,   0,'h0,          0,'h80, 'h80, 'hC000_0080,  1,'h200));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   0,'h0,          0,'h80, 'h80, 'hC000_0080,  1,'h200));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0200,  1,'h200,'h200,'hC000_0200,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 1,'h80,  0,'h0, 0,'h0,   1,'hC000_0204,  1,'h204,'h204,NOP,          0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0080,  1,'h80, 'h80, 'hC000_0080,  0,'h0));
    tbl.push_back(mk(0,0,0,0, 0,'h0,   0,'h0, 0,'h0,   1,'hC000_0084,  1,'h84, 'h84, 'hC000_0084,  0,'h0));

    for (int i = 0; i < tbl.size(); i++) run(tbl[i], i);

    // Reset while waiting at 0x88: the late response lands inside reset and is ignored.
    run(mk(0,0,0,0, 0,'h0, 0,'h0,0,'h0, 0,'h0,          1,'h88, 'h88, NOP,         0,'h0), 100);
    run(mk(1,0,0,0, 0,'h0, 0,'h0,0,'h0, 1,'hDEAD_BEEF,  0,'h88, 'h0,  NOP,         0,'h0), 101);
    run(mk(0,0,0,0, 0,'h0, 0,'h0,0,'h0, 0,'h0,          1,'h0,  'h0,  NOP,         0,'h0), 102);
    run(mk(0,0,0,0, 0,'h0, 0,'h0,0,'h0, 1,'hC000_0000,  0,'h0,  'h0,  'hC000_0000, 0,'h0), 103);
    // Sequential PC wraps from the top of the address space to zero.
    run(mk(0,0,0,0, 1,'hFFFF_FFFC, 0,'h0,0,'h0, 1,'hC000_0004, 1,'h4, 'h4, NOP, 0,'h0), 104);
    run(mk(0,0,0,0, 0,'h0, 0,'h0,0,'h0, 1,'hC000_00FC,  1,'hFFFF_FFFC,'hFFFF_FFFC,'hC000_00FC, 0,'h0), 105);
    run(mk(0,0,0,0, 0,'h0, 0,'h0,0,'h0, 0,'h0,          1,'h0,  'h0,  NOP,         0,'h0), 106);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
